audio_deserializer: RTL and testbench

AUDIO_DESERIALIZER -- requirements
Module: audio_deserializer

---
 rtl/audio_pkg.sv | 17 +
 rtl/audio_edge_detector.sv | 43 ++++
 rtl/audio_deserializer.sv | 152 +++++++++++++++
 tb/tb_audio_deserializer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared constants and types for the I2S audio blocks.
package audio_pkg;

   localparam int unsigned AUDIO_DATA_WIDTH  = 24;
   localparam int unsigned AUDIO_COUNT_WIDTH = 5;

   typedef enum logic [2:0] {
      StIdle,
      StLeftSkip,
      StLeftShift,
      StWaitLrRising,
      StRightSkip,
      StRightShift,
      StWaitLrFalling
   } deser_state_t;

endpackage

// File: rtl/audio_edge_detector.sv
// Synchronises one asynchronous codec line, adds a delay flop and produces
// registered single-cycle rising/falling pulses.
module audio_edge_detector #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_signal,
   output logic o_delayed,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_delay;
   logic                   r_rise;
   logic                   r_fall;
   logic                   w_stable;

   assign w_stable = r_sync[SYNC_STAGES-1];

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_sync  <= '0;
         r_delay <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_sync[0] <= i_signal;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
         r_delay <= w_stable;
         r_rise  <= w_stable & ~r_delay;
         r_fall  <= ~w_stable & r_delay;
      end
   end

   assign o_delayed = r_delay;
   assign o_rise    = r_rise;
   assign o_fall    = r_fall;

endmodule

// File: rtl/audio_deserializer.sv
// I2S receiver: collects one left/right sample pair per LRCLK frame and
// presents it with a one-cycle valid pulse; short slots raise a frame error.
module audio_deserializer
   import audio_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = AUDIO_DATA_WIDTH,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_codec_bit_clock,
   input  logic                  i_codec_lr_clock,
   input  logic                  i_codec_adc_data,
   output logic [DATA_WIDTH-1:0] o_data_left,
   output logic [DATA_WIDTH-1:0] o_data_right,
   output logic                  o_data_valid,
   output logic                  o_frame_error
);

   localparam logic [AUDIO_COUNT_WIDTH-1:0] LAST_BIT = AUDIO_COUNT_WIDTH'(DATA_WIDTH - 1);

   deser_state_t                 r_state, w_state_next;
   logic [AUDIO_COUNT_WIDTH-1:0] r_count, w_count_next;
   logic [DATA_WIDTH-1:0]        r_shift_left, r_shift_right;
   logic [DATA_WIDTH-1:0]        r_data_left, r_data_right;
   logic                         r_data_valid, r_frame_error;

   logic w_bclk_rise, w_bclk_fall, w_bclk_delayed;
   logic w_lr_rise, w_lr_fall, w_lr_delayed;
   logic w_data_bit, w_data_rise, w_data_fall;
   logic w_lr_edge, w_last_bit;
   logic w_shift_left, w_shift_right, w_valid, w_frame_error;
   logic w_unused_edges;

   audio_edge_detector #(.SYNC_STAGES(SYNC_STAGES)) u_bclk_edge (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_signal (i_codec_bit_clock),
      .o_delayed(w_bclk_delayed),
      .o_rise   (w_bclk_rise),
      .o_fall   (w_bclk_fall)
   );

   audio_edge_detector #(.SYNC_STAGES(SYNC_STAGES)) u_lr_edge (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_signal (i_codec_lr_clock),
      .o_delayed(w_lr_delayed),
      .o_rise   (w_lr_rise),
      .o_fall   (w_lr_fall)
   );

   // Data delayed flop lines up with the registered BCLK rising pulse.
   audio_edge_detector #(.SYNC_STAGES(SYNC_STAGES)) u_data_edge (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_signal (i_codec_adc_data),
      .o_delayed(w_data_bit),
      .o_rise   (w_data_rise),
      .o_fall   (w_data_fall)
   );

   assign w_unused_edges = ^{w_bclk_fall, w_bclk_delayed, w_lr_delayed, w_data_rise, w_data_fall};
   assign w_lr_edge      = w_lr_rise | w_lr_fall;
   assign w_last_bit     = (r_count == LAST_BIT);

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StIdle:          if (w_lr_fall) w_state_next = StLeftSkip;
         StLeftSkip:      if (w_lr_edge) w_state_next = StIdle;
                          else if (w_bclk_rise) w_state_next = StLeftShift;
         StLeftShift:     if (w_lr_edge) w_state_next = StIdle;
                          else if (w_bclk_rise && w_last_bit) w_state_next = StWaitLrRising;
         StWaitLrRising:  if (w_lr_rise) w_state_next = StRightSkip;
         StRightSkip:     if (w_lr_edge) w_state_next = StIdle;
                          else if (w_bclk_rise) w_state_next = StRightShift;
         StRightShift:    if (w_lr_edge) w_state_next = StIdle;
                          else if (w_bclk_rise && w_last_bit) w_state_next = StWaitLrFalling;
         StWaitLrFalling: if (w_lr_fall) w_state_next = StLeftSkip;
         default:         w_state_next = StIdle;
      endcase
   end

   // An LR edge wins over a coincident BCLK rise: the bit is dropped.
   always_comb begin
      w_shift_left  = 1'b0;
      w_shift_right = 1'b0;
      w_frame_error = 1'b0;
      case (r_state)
         StLeftSkip, StRightSkip: w_frame_error = w_lr_edge;
         StLeftShift: begin
            w_frame_error = w_lr_edge;
            w_shift_left  = w_bclk_rise & ~w_lr_edge;
         end
         StRightShift: begin
            w_frame_error = w_lr_edge;
            w_shift_right = w_bclk_rise & ~w_lr_edge;
         end
         default: ;
      endcase
      w_valid = w_shift_right & w_last_bit;
      if (w_frame_error) begin
         w_count_next = '0;
      end else if (w_shift_left || w_shift_right) begin
         w_count_next = w_last_bit ? '0 : r_count + 1'b1;
      end else begin
         w_count_next = r_count;
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_count       <= '0;
         r_shift_left  <= '0;
         r_shift_right <= '0;
         r_data_left   <= '0;
         r_data_right  <= '0;
         r_data_valid  <= 1'b0;
         r_frame_error <= 1'b0;
      end else begin
         r_count       <= w_count_next;
         r_data_valid  <= w_valid;
         r_frame_error <= w_frame_error;
         if (w_shift_left) begin
            r_shift_left <= {r_shift_left[DATA_WIDTH-2:0], w_data_bit};
         end
         if (w_shift_right) begin
            r_shift_right <= {r_shift_right[DATA_WIDTH-2:0], w_data_bit};
         end
         // Right LSB arrives this cycle, so load it straight from the data line.
         if (w_valid) begin
            r_data_left  <= r_shift_left;
            r_data_right <= {r_shift_right[DATA_WIDTH-2:0], w_data_bit};
         end
      end
   end

   assign o_data_left   = r_data_left;
   assign o_data_right  = r_data_right;
   assign o_data_valid  = r_data_valid;
   assign o_frame_error = r_frame_error;

endmodule

// File: tb/tb_audio_deserializer.sv
// Directed I2S frames with a scoreboard of expected left/right pairs that a
// monitor pops on every o_data_valid pulse.
module tb_audio_deserializer;
   import audio_pkg::*;

   localparam int unsigned DW        = AUDIO_DATA_WIDTH;
   localparam int unsigned HALF_BCLK = 8;

   logic          i_clock = 1'b0;
   logic          i_reset;
   logic          bclk, lrclk, adc;
   logic [DW-1:0] o_data_left, o_data_right;
   logic          o_data_valid, o_frame_error;

   int              n_checks = 0;
   int              n_errors = 0;
   int              n_valid  = 0;
   int              n_ferr   = 0;
   logic            prev_valid = 1'b0;
   logic [2*DW-1:0] exp_q[$];

   always #5 i_clock = ~i_clock;

   audio_deserializer #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
      .i_clock          (i_clock),
      .i_reset          (i_reset),
      .i_codec_bit_clock(bclk),
      .i_codec_lr_clock (lrclk),
      .i_codec_adc_data (adc),
      .o_data_left      (o_data_left),
      .o_data_right     (o_data_right),
      .o_data_valid     (o_data_valid),
      .o_frame_error    (o_frame_error)
   );

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   always @(negedge i_clock) begin
      if (o_frame_error === 1'b1) n_ferr++;
      if (o_data_valid === 1'b1) begin
         logic [2*DW-1:0] pair;
         n_valid++;
         check("valid_single_cycle", DW'(prev_valid), '0);
         n_checks++;
         assert (exp_q.size() != 0) else begin
            n_errors++;
            $error("FAIL unexpected_valid: observed=valid expected=no valid");
         end
         if (exp_q.size() != 0) begin
            pair = exp_q.pop_front();
            check("left_sample", o_data_left, pair[2*DW-1:DW]);
            check("right_sample", o_data_right, pair[DW-1:0]);
         end
      end
      prev_valid <= o_data_valid;
   end

   task automatic clk_wait(input int n);
      repeat (n) @(negedge i_clock);
   endtask

   // Codec drives LR and data on BCLK falling; receiver samples on BCLK rising.
   task automatic send_bit(input logic lr, input logic b);
      bclk  = 1'b0;
      lrclk = lr;
      adc   = b;
      clk_wait(HALF_BCLK);
      bclk = 1'b1;
      clk_wait(HALF_BCLK);
   endtask

   // Slot = one delay bit, DW data bits MSB first, then random padding.
   task automatic send_slot(input logic lr, input logic [DW-1:0] val, input int n_bclk);
      for (int i = 0; i < n_bclk; i++) begin
         logic b;
         if (i >= 1 && i <= int'(DW)) b = val[int'(DW) - i];
         else b = 1'($urandom);
         send_bit(lr, b);
      end
   endtask

   task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int slot);
      exp_q.push_back({l, r});
      send_slot(1'b0, l, slot);
      send_slot(1'b1, r, slot);
   endtask

   initial begin
      i_reset = 1'b1;
      bclk    = 1'b0;
      lrclk   = 1'b0;
      adc     = 1'b0;
      clk_wait(3);
      check("reset_left", o_data_left, '0);
      check("reset_right", o_data_right, '0);
      check("reset_valid", DW'(o_data_valid), '0);
      check("reset_ferr", DW'(o_frame_error), '0);
      i_reset = 1'b0;
      clk_wait(3);

      // Begin mid-right-slot so the first frame opens with an LRCLK fall.
      send_slot(1'b1, DW'($urandom), 10);
      send_frame(24'h800001, 24'h7FFFFE, 32);
      check("basic_valid_count", DW'(n_valid), DW'(1));
      check("basic_ferr_count", DW'(n_ferr), '0);

      send_frame(24'h123456, 24'hABCDEF, 32);
      exp_q.push_back({24'h000000, 24'hFFFFFF});
      send_slot(1'b0, 24'h000000, 32);
      check("hold_left", o_data_left, 24'h123456);
      check("hold_right", o_data_right, 24'hABCDEF);
      send_slot(1'b1, 24'hFFFFFF, 32);
      clk_wait(20);
      check("hold2_left", o_data_left, 24'h000000);
      check("hold2_right", o_data_right, 24'hFFFFFF);
      check("b2b_valid_count", DW'(n_valid), DW'(3));

      // LRCLK toggles after ten left bits.
      send_slot(1'b0, 24'h3C3C3C, 11);
      send_slot(1'b1, DW'($urandom), 32);
      check("short_ferr_count", DW'(n_ferr), DW'(1));
      check("short_valid_count", DW'(n_valid), DW'(3));
      send_frame(24'h654321, 24'h0F0F0F, 32);
      check("recover_valid_count", DW'(n_valid), DW'(4));

      // Reset in the middle of the right slot.
      send_slot(1'b0, 24'h111111, 32);
      send_slot(1'b1, 24'h222222, 12);
      bclk    = 1'b0;
      i_reset = 1'b1;
      #1;
      check("midreset_left", o_data_left, '0);
      check("midreset_right", o_data_right, '0);
      check("midreset_valid", DW'(o_data_valid), '0);
      clk_wait(4);
      i_reset = 1'b0;
      send_slot(1'b1, DW'($urandom), 20);
      check("postreset_no_valid", DW'(n_valid), DW'(4));
      send_frame(24'hC0FFEE, 24'h13579B, 32);
      check("postreset_valid_count", DW'(n_valid), DW'(5));

      // Reset released with LRCLK already high.
      i_reset = 1'b1;
      lrclk   = 1'b1;
      clk_wait(4);
      i_reset = 1'b0;
      send_slot(1'b1, DW'($urandom), 16);
      check("lrhigh_no_valid", DW'(n_valid), DW'(5));
      send_frame(24'h2468AC, 24'hFDB975, 32);
      check("lrhigh_valid_count", DW'(n_valid), DW'(6));

      // Minimum slots: delay bit plus exactly DW data bits, no padding.
      send_frame(24'h5A5A5A, 24'hA5A5A5, int'(DW) + 1);
      send_frame(24'h3C3C3C, 24'hC3C3C3, int'(DW) + 1);
      clk_wait(20);
      check("exact_valid_count", DW'(n_valid), DW'(8));
      check("exact_ferr_count", DW'(n_ferr), DW'(1));
      check("scoreboard_empty", DW'(exp_q.size()), '0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
